// File: rtl/store_write_buffer_pkg.sv
// Shared memory-system definitions for the store write buffer.
package store_write_buffer_pkg;

    localparam int SWB_DEPTH  = 4;
    localparam int SWB_ADDR_W = 32;
    localparam int SWB_DATA_W = 32;

    // Drain FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } swb_state_e;

endpackage

// File: rtl/store_write_buffer_chk.sv
// Simulation-only protocol checks for the store write buffer.
module store_write_buffer_chk #(
    parameter bit EN = 1'b1
) (
    input logic clk,
    input logic reset_ms,
    input logic push_drop,
    input logic stray_ack
);

    // Flag a store lost to a full buffer and an ack arriving outside a request
    always_ff @(posedge clk) begin
        if (EN && !reset_ms) begin
            a_no_drop: assert (!push_drop)
                else $error("store_write_buffer: push while full without coalesce");
            a_no_stray_ack: assert (!stray_ack)
                else $error("store_write_buffer: mem_wr_ack outside REQ");
        end
    end

endmodule

// File: rtl/store_write_buffer_wb_fifo_core.sv
// Circular entry store for the write buffer: pointers, occupancy, valid bits
// and payload, with push / pop / coalesce controls decided by the parent.
module wb_fifo_core
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH  = SWB_DEPTH,
    parameter int ADDR_W = SWB_ADDR_W,
    parameter int DATA_W = SWB_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          reset_ms,
    input  logic                          push_en,
    input  logic                          coal_en,
    input  logic                          pop_en,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [DATA_W-1:0]             in_data,
    output logic [PTR_W-1:0]              head_ptr,
    output logic [CNT_W-1:0]              count,
    output logic [CNT_W-1:0]              count_next,
    output logic                          full,
    output logic [ADDR_W-1:0]             youngest_addr,
    output logic [DEPTH-1:0]              ent_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]  ent_data
);

    logic [PTR_W-1:0]             head_r;
    logic [PTR_W-1:0]             tail_r;
    logic [PTR_W-1:0]             young_s;
    logic [CNT_W-1:0]             count_r;
    logic [CNT_W-1:0]             count_next_s;
    logic                         full_r;
    logic [DEPTH-1:0]             vld_r;
    logic [DEPTH-1:0]             vld_next_s;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_r;
    logic [DEPTH-1:0][DATA_W-1:0] data_r;

    // Youngest slot, next occupancy and next valid vector (set at tail, clear at head)
    always_comb begin
        young_s      = tail_r - PTR_W'(1);
        count_next_s = count_r + CNT_W'(push_en) - CNT_W'(pop_en);
        vld_next_s   = (vld_r | ({{(DEPTH-1){1'b0}}, push_en} << tail_r))
                     & ~({{(DEPTH-1){1'b0}}, pop_en} << head_r);
    end

    // Pointer, occupancy, full flag and valid-bit registers
    always_ff @(posedge clk) begin
        if (reset_ms) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            full_r  <= 1'b0;
            vld_r   <= {DEPTH{1'b0}};
        end else begin
            head_r  <= pop_en  ? head_r + PTR_W'(1) : head_r;
            tail_r  <= push_en ? tail_r + PTR_W'(1) : tail_r;
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_W'(DEPTH));
            vld_r   <= vld_next_s;
        end
    end

    // Payload writes: new entry at tail, or coalesced data into the youngest entry
    always_ff @(posedge clk) begin
        if (push_en) begin
            addr_r[tail_r] <= in_addr;
            data_r[tail_r] <= in_data;
        end else if (coal_en) begin
            data_r[young_s] <= in_data;
        end
    end

    assign head_ptr      = head_r;
    assign count         = count_r;
    assign count_next    = count_next_s;
    assign full          = full_r;
    assign youngest_addr = addr_r[young_s];
    assign ent_vld       = vld_r;
    assign ent_addr      = addr_r;
    assign ent_data      = data_r;

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer between the write-through cache and data memory:
// in-order drain over req/ack, youngest-entry coalescing, read forwarding.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH     = SWB_DEPTH,
    parameter int ADDR_W    = SWB_ADDR_W,
    parameter int DATA_W    = SWB_DATA_W,
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_ms,
    input  logic              wb_push,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_full,
    output logic              wb_empty,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    swb_state_e                   state_r, state_next_s;
    logic                         in_flight_only_s, coal_s, accept_s, pop_s;
    logic                         drop_s, stray_ack_s;
    logic                         req_r, req_next_s, empty_r, empty_next_s;
    logic [PTR_W-1:0]             head_s, idx_s;
    logic [CNT_W-1:0]             count_s, count_next_s;
    logic                         full_s, match_s, rd_hit_s;
    logic [DATA_W-1:0]            rd_data_s;
    logic [ADDR_W-1:0]            young_addr_s;
    logic [DEPTH-1:0]             ent_vld_s;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_s;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data_s;

    wb_fifo_core #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_core (
        .clk(clk), .reset_ms(reset_ms),
        .push_en(accept_s), .coal_en(coal_s), .pop_en(pop_s),
        .in_addr(wb_addr), .in_data(wb_data),
        .head_ptr(head_s), .count(count_s), .count_next(count_next_s),
        .full(full_s), .youngest_addr(young_addr_s),
        .ent_vld(ent_vld_s), .ent_addr(ent_addr_s), .ent_data(ent_data_s)
    );

    // Push/pop decode; the sole entry is untouchable while it is being written
    always_comb begin
        in_flight_only_s = (state_r == ST_REQ) && (count_s == CNT_W'(1));
        coal_s      = wb_push && (count_s != {CNT_W{1'b0}})
                      && (young_addr_s == wb_addr) && !in_flight_only_s;
        accept_s    = wb_push && !coal_s && !full_s;
        drop_s      = wb_push && !coal_s && full_s;
        pop_s       = (state_r == ST_REQ) && mem_wr_ack;
        stray_ack_s = mem_wr_ack && (state_r != ST_REQ);
    end

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (reset_ms) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Drain FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = ((count_s != {CNT_W{1'b0}}) || accept_s) ? ST_REQ : ST_IDLE;
            ST_REQ:  state_next_s = mem_wr_ack ? ST_GAP : ST_REQ;
            ST_GAP:  state_next_s = (count_s != {CNT_W{1'b0}}) ? ST_REQ : ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Drain FSM outputs, computed one cycle early so they can be registered
    always_comb begin
        req_next_s   = (state_next_s == ST_REQ);
        empty_next_s = (count_next_s == {CNT_W{1'b0}}) && (state_next_s == ST_IDLE);
    end

    // Registered request and empty flags
    always_ff @(posedge clk) begin
        if (reset_ms) begin
            req_r   <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            req_r   <= req_next_s;
            empty_r <= empty_next_s;
        end
    end

    // Forwarding search from oldest to newest so the newest match wins
    always_comb begin
        rd_hit_s  = 1'b0;
        rd_data_s = {DATA_W{1'b0}};
        idx_s     = head_s;
        match_s   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s     = head_s + PTR_W'(i);
            match_s   = ent_vld_s[idx_s] && (ent_addr_s[idx_s] == rd_addr);
            rd_hit_s  = rd_hit_s | match_s;
            rd_data_s = match_s ? ent_data_s[idx_s] : rd_data_s;
        end
    end

    store_write_buffer_chk #(.EN(ASSERT_EN)) u_chk (
        .clk(clk), .reset_ms(reset_ms),
        .push_drop(drop_s), .stray_ack(stray_ack_s)
    );

    assign wb_full     = full_s;
    assign wb_empty    = empty_r;
    assign mem_wr_req  = req_r;
    assign mem_wr_addr = ent_addr_s[head_s];
    assign mem_wr_data = ent_data_s[head_s];
    assign rd_hit      = rd_hit_s;
    assign rd_data     = rd_data_s;

endmodule
